i2c_bus_arbiter: RTL and testbench

Round-robin arbiter and transaction sequencer that shares the single `i2c_master` control port among `NUM_REQ` independent requesters, e.g. the LED, FND and switch service engines in the multi-slave system. It sits between the requesters and the master's `start/rw_bit/slave_addr/tx_data` interface. It latches one request, issues exactly one `start` pulse and waits for `done`. It then returns read data and error status to the granted requester. A watchdog aborts transactions that never complete.

---
 rtl/i2c_arb_pkg.sv | 18 +
 rtl/i2c_rr_pick.sv | 36 +++
 rtl/i2c_bus_arbiter.sv | 171 +++++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C bus arbiter.
//   arb_state_t             : arbiter sequencer states
//   I2C_ADDR_W / I2C_DATA_W : 7-bit slave address, 8-bit data byte
//   DEFAULT_TIMEOUT_CYCLES  : watchdog limit in WAIT_DONE (2 ms at 100 MHz)
package i2c_arb_pkg;

    localparam int unsigned I2C_ADDR_W             = 7;
    localparam int unsigned I2C_DATA_W             = 8;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 200000;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        RESP
    } arb_state_t;

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational rotate-priority picker.
//   req   : request vector
//   last  : index of the most recently served requester
//   valid : at least one request is pending
//   grant : one-hot winner (first set bit searching upward from last+1, wrapping)
//   idx   : binary index of the winner
module i2c_rr_pick #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               valid,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    int unsigned j;

    always_comb begin
        valid = 1'b0;
        grant = '0;
        idx   = '0;
        j     = 0;
        // Offsets 1..NUM_REQ visit last+1 first and last itself at the end.
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            j = (32'(last) + i) % NUM_REQ;
            if (!valid && req[j]) begin
                valid    = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter and transaction sequencer sharing one i2c_master
// control port among NUM_REQ requesters.
//   req/req_rw/req_addr/req_wdata : per-requester request level and fields
//   req_grant                     : one-hot served requester (ISSUE..RESP)
//   req_done/req_err              : one-cycle completion pulse and its error qualifier
//   req_rdata                     : per-requester last successfully read byte
//   m_*                           : master start/rw/addr/tx_data and rx/busy/done/ack_error
//   timeout_flag                  : sticky watchdog-abort indicator
module i2c_bus_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 3,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              req_rw,
    input  logic [NUM_REQ*I2C_ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*I2C_DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              req_grant,
    output logic [NUM_REQ-1:0]              req_done,
    output logic [NUM_REQ-1:0]              req_err,
    output logic [NUM_REQ*I2C_DATA_W-1:0]   req_rdata,
    output logic                            m_start,
    output logic                            m_rw,
    output logic [I2C_ADDR_W-1:0]           m_addr,
    output logic [I2C_DATA_W-1:0]           m_tx_data,
    input  logic [I2C_DATA_W-1:0]           m_rx_data,
    input  logic                            m_busy,
    input  logic                            m_done,
    input  logic                            m_ack_error,
    output logic                            timeout_flag
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    arb_state_t                      state_q, state_d;
    logic [IDX_W-1:0]                last_q, last_d;
    logic [IDX_W-1:0]                gidx_q, gidx_d;
    logic [NUM_REQ-1:0]              grant_q, grant_d;
    logic                            rw_q, rw_d;
    logic [I2C_ADDR_W-1:0]           addr_q, addr_d;
    logic [I2C_DATA_W-1:0]           wdata_q, wdata_d;
    logic [WD_W-1:0]                 wd_q, wd_d;
    logic [NUM_REQ-1:0]              done_q, done_d;
    logic [NUM_REQ-1:0]              err_q, err_d;
    logic [NUM_REQ*I2C_DATA_W-1:0]   rdata_q, rdata_d;
    logic                            timeout_q, timeout_d;

    logic                            pick_valid;
    logic [NUM_REQ-1:0]              pick_grant;
    logic [IDX_W-1:0]                pick_idx;

    i2c_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (req),
        .last  (last_q),
        .valid (pick_valid),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gidx_d    = gidx_q;
        grant_d   = grant_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wd_d      = wd_q;
        done_d    = '0;
        err_d     = '0;
        rdata_d   = rdata_q;
        timeout_d = timeout_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = ISSUE;
                    gidx_d  = pick_idx;
                    grant_d = pick_grant;
                    rw_d    = req_rw[pick_idx];
                    addr_d  = req_addr[32'(pick_idx)*I2C_ADDR_W +: I2C_ADDR_W];
                    wdata_d = req_wdata[32'(pick_idx)*I2C_DATA_W +: I2C_DATA_W];
                end
            end
            ISSUE: begin
                if (!m_busy) begin
                    state_d = WAIT_DONE;
                    wd_d    = '0;
                end
            end
            WAIT_DONE: begin
                // Completion and response flags are registered on the way into
                // RESP so that req_done, req_err and req_rdata appear together.
                if (m_done) begin
                    state_d        = RESP;
                    done_d[gidx_q] = 1'b1;
                    err_d[gidx_q]  = m_ack_error;
                    if (rw_q && !m_ack_error) begin
                        rdata_d[32'(gidx_q)*I2C_DATA_W +: I2C_DATA_W] = m_rx_data;
                    end
                end else if (wd_q == WD_LAST) begin
                    state_d        = RESP;
                    done_d[gidx_q] = 1'b1;
                    err_d[gidx_q]  = 1'b1;
                    timeout_d      = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                grant_d = '0;
                last_d  = gidx_q;
                wd_d    = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= IDX_W'(NUM_REQ - 1);
            gidx_q    <= '0;
            grant_q   <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wd_q      <= '0;
            done_q    <= '0;
            err_q     <= '0;
            rdata_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gidx_q    <= gidx_d;
            grant_q   <= grant_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wd_q      <= wd_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            timeout_q <= timeout_d;
        end
    end

    // start must react to m_busy in the same cycle, so it is decoded from state.
    assign m_start      = (state_q == ISSUE) && !m_busy;
    assign m_rw         = rw_q;
    assign m_addr       = addr_q;
    assign m_tx_data    = wdata_q;
    assign req_grant    = grant_q;
    assign req_done     = done_q;
    assign req_err      = err_q;
    assign req_rdata    = rdata_q;
    assign timeout_flag = timeout_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
module tb_i2c_bus_arbiter;

    localparam int NREQ = 3;
    localparam int TMO  = 50;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   req_rw;
    logic [NREQ*7-1:0] req_addr;
    logic [NREQ*8-1:0] req_wdata;
    logic [NREQ-1:0]   req_grant;
    logic [NREQ-1:0]   req_done;
    logic [NREQ-1:0]   req_err;
    logic [NREQ*8-1:0] req_rdata;
    logic              m_start;
    logic              m_rw;
    logic [6:0]        m_addr;
    logic [7:0]        m_tx_data;
    logic [7:0]        m_rx_data;
    logic              m_busy;
    logic              m_done;
    logic              m_ack_error;
    logic              timeout_flag;

    int n_checks = 0;
    int n_errors = 0;
    int start_cnt = 0;

    always #5 clk = ~clk;

    i2c_bus_arbiter #(
        .NUM_REQ        (NREQ),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_rw       (req_rw),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_grant    (req_grant),
        .req_done     (req_done),
        .req_err      (req_err),
        .req_rdata    (req_rdata),
        .m_start      (m_start),
        .m_rw         (m_rw),
        .m_addr       (m_addr),
        .m_tx_data    (m_tx_data),
        .m_rx_data    (m_rx_data),
        .m_busy       (m_busy),
        .m_done       (m_done),
        .m_ack_error  (m_ack_error),
        .timeout_flag (timeout_flag)
    );

    always @(posedge clk) begin
        if (m_start) start_cnt <= start_cnt + 1;
    end

    typedef struct {
        int         r;
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic       ack_err;
        logic [7:0] rx;
        int         busy;
        int         lat;
        logic       exp_err;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_fields(input int r, input logic rw, input logic [6:0] a, input logic [7:0] d);
        req_rw[r]          = rw;
        req_addr[r*7 +: 7] = a;
        req_wdata[r*8 +: 8] = d;
    endtask

    task automatic run_txn(input vec_t v);
        int s0;
        s0 = start_cnt;
        @(negedge clk);
        set_fields(v.r, v.rw, v.addr, v.wdata);
        req[v.r] = 1'b1;
        m_busy   = (v.busy > 0);
        @(negedge clk);
        check("grant_issue", 32'(req_grant), 32'(1 << v.r));
        for (int i = 0; i < v.busy; i++) begin
            check("start_while_busy", 32'(m_start), 32'(0));
            @(negedge clk);
        end
        m_busy = 1'b0;
        #1;
        check("m_start", 32'(m_start), 32'(1));
        check("m_addr", 32'(m_addr), 32'(v.addr));
        check("m_rw", 32'(m_rw), 32'(v.rw));
        check("m_tx_data", 32'(m_tx_data), 32'(v.wdata));
        for (int i = 0; i < v.lat; i++) @(negedge clk);
        @(negedge clk);
        m_done      = 1'b1;
        m_rx_data   = v.rx;
        m_ack_error = v.ack_err;
        @(negedge clk);
        m_done      = 1'b0;
        m_ack_error = 1'b0;
        check("req_done", 32'(req_done), 32'(1 << v.r));
        check("req_err", 32'(req_err), 32'(v.exp_err) << v.r);
        check("req_rdata", 32'(req_rdata[v.r*8 +: 8]), 32'(v.exp_rd));
        check("grant_resp", 32'(req_grant), 32'(1 << v.r));
        check("m_addr_hold", 32'(m_addr), 32'(v.addr));
        req[v.r] = 1'b0;
        @(negedge clk);
        check("done_pulse_end", 32'(req_done), 32'(0));
        check("grant_idle", 32'(req_grant), 32'(0));
        check("start_count", 32'(start_cnt - s0), 32'(1));
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int k;
        int s0;
        vec_t v;

        rst = 1'b1; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
        m_rx_data = '0; m_busy = 1'b0; m_done = 1'b0; m_ack_error = 1'b0;

        //         r  rw    addr   wdata  ackerr rx     busy lat experr exp_rd
        vecs[0] = '{1, 1'b0, 7'h55, 8'hA5, 1'b0, 8'h00, 0,  3,  1'b0, 8'h00};
        vecs[1] = '{2, 1'b1, 7'h57, 8'h00, 1'b0, 8'h3C, 0,  2,  1'b0, 8'h3C};
        vecs[2] = '{0, 1'b1, 7'h20, 8'h00, 1'b0, 8'h99, 0,  1,  1'b0, 8'h99};
        vecs[3] = '{0, 1'b1, 7'h20, 8'h00, 1'b1, 8'h11, 0,  1,  1'b1, 8'h99};
        vecs[4] = '{2, 1'b0, 7'h57, 8'h77, 1'b1, 8'hEE, 0,  0,  1'b1, 8'h3C};
        vecs[5] = '{1, 1'b0, 7'h10, 8'h01, 1'b0, 8'h00, 10, 0,  1'b0, 8'h00};
        vecs[6] = '{2, 1'b1, 7'h57, 8'h00, 1'b0, 8'hC3, 0,  0,  1'b0, 8'hC3};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ctrl", 32'({req_grant, req_done, req_err, m_start, m_rw, m_addr, m_tx_data, timeout_flag}), 32'(0));
        check("reset_rdata", 32'(req_rdata), 32'(0));

        // Round robin: all three raised together, each re-raised once.
        s0 = start_cnt;
        for (int i = 0; i < NREQ; i++) set_fields(i, 1'b0, 7'(7'h30 + i), 8'(8'h40 + i));
        req = '1;
        for (int t = 0; t < 6; t++) begin
            k = 0;
            while (!m_start && k < 50) begin
                @(negedge clk);
                k++;
            end
            check("rr_start_seen", 32'(m_start), 32'(1));
            check("rr_grant", 32'(req_grant), 32'(1 << (t % 3)));
            check("rr_addr", 32'(m_addr), 32'(7'h30 + t % 3));
            @(negedge clk);
            m_done = 1'b1;
            @(negedge clk);
            m_done = 1'b0;
            check("rr_done", 32'(req_done), 32'(1 << (t % 3)));
            req[t % 3] = 1'b0;
            @(negedge clk);
            if (t < 3) req[t % 3] = 1'b1;
        end
        repeat (3) @(negedge clk);
        check("rr_start_total", 32'(start_cnt - s0), 32'(6));

        for (int i = 0; i < 7; i++) run_txn(vecs[i]);

        // m_done on the watchdog terminal cycle: completion wins, no error.
        @(negedge clk);
        set_fields(0, 1'b1, 7'h21, 8'h00);
        req[0] = 1'b1;
        @(negedge clk);
        check("tc_start", 32'(m_start), 32'(1));
        for (int i = 0; i < TMO; i++) @(negedge clk);
        m_done = 1'b1; m_rx_data = 8'h5A;
        @(negedge clk);
        m_done = 1'b0;
        check("tc_done", 32'(req_done), 32'(1));
        check("tc_err", 32'(req_err), 32'(0));
        check("tc_rdata", 32'(req_rdata[7:0]), 32'(8'h5A));
        check("tc_flag", 32'(timeout_flag), 32'(0));
        req[0] = 1'b0;
        @(negedge clk);

        // Watchdog abort: m_done never arrives.
        @(negedge clk);
        set_fields(1, 1'b1, 7'h22, 8'h00);
        req[1] = 1'b1;
        @(negedge clk);
        check("to_start", 32'(m_start), 32'(1));
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (req_done == '0 && k < 200);
        check("to_latency", 32'(k), 32'(TMO + 1));
        check("to_done", 32'(req_done), 32'(3'b010));
        check("to_err", 32'(req_err), 32'(3'b010));
        check("to_flag", 32'(timeout_flag), 32'(1));
        check("to_rdata_kept", 32'(req_rdata[15:8]), 32'(8'h00));
        req[1] = 1'b0;
        @(negedge clk);

        v = '{2, 1'b1, 7'h57, 8'h00, 1'b0, 8'h81, 0, 1, 1'b0, 8'h81};
        run_txn(v);
        check("to_flag_sticky", 32'(timeout_flag), 32'(1));

        // Reset during WAIT_DONE.
        @(negedge clk);
        set_fields(1, 1'b0, 7'h33, 8'hF0);
        req[1] = 1'b1;
        @(negedge clk);
        check("rst_start", 32'(m_start), 32'(1));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_ctrl", 32'({req_grant, req_done, req_err, m_start, m_rw, m_addr, m_tx_data, timeout_flag}), 32'(0));
        check("rst_rdata", 32'(req_rdata), 32'(0));
        req[1] = 1'b0;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) rst = 1'b0;
            if (req_done != '0) k++;
        end
        check("rst_no_done", 32'(k), 32'(0));
        check("rst_grant_idle", 32'(req_grant), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
